// File: rtl/keypad_pkg.sv
// Shared types, decode table and helpers for the keypad scanner.
package keypad_pkg;

   typedef enum logic [0:0] {SCAN, HOLD} scan_state_t;

   // Key codes packed as 16 nibbles, entry {row,col} at bits [{row,col}*4 +: 4].
   // row0: 1 2 3 A / row1: 4 5 6 B / row2: 7 8 9 C / row3: E 0 F D
   localparam logic [63:0] KeyTable = 64'hDF0E_C987_B654_A321;

   function automatic logic [3:0] decode_key(input logic [1:0] row, input logic [1:0] col);
      logic [5:0] base;
      base = {row, col, 2'b00};
      return KeyTable[base +: 4];
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for the active-low keypad rows; idles high.
module sync2 (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [3:0] d_i,
   output logic [3:0] q_o
);

   logic [3:0] meta_q;
   logic [3:0] sync_q;

   // Shift the asynchronous rows through two flops.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         meta_q <= 4'hF;
         sync_q <= 4'hF;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner: locks onto a pressed key until a confirmed release.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES  = 8,
   parameter int unsigned RELEASE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] keyDecoded,
   output logic       keyPressed
);

   localparam logic [7:0] SettleLast  = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0] ReleaseLast = 8'(RELEASE_CYCLES - 1);

   logic [3:0]  row_sync;
   scan_state_t state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  col_idx_q, col_idx_d;
   logic [1:0]  row_idx_q, row_idx_d;
   logic [3:0]  key_q, key_d;
   logic        pressed_q, pressed_d;
   logic [3:0]  cols_q, cols_d;
   logic [1:0]  low_row;

   sync2 u_sync2 (
      .clk_i  (clk),
      .rst_ni (reset),
      .d_i    (rows),
      .q_o    (row_sync)
   );

   // Lowest-index low row wins when several rows are pulled down.
   always_comb begin
      low_row = 2'd3;
      priority casez (row_sync)
         4'b???0: low_row = 2'd0;
         4'b??01: low_row = 2'd1;
         4'b?011: low_row = 2'd2;
         default: low_row = 2'd3;
      endcase
   end

   // Scan/hold next-state logic; the counter is shared between settle and release timing.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      col_idx_d = col_idx_q;
      row_idx_d = row_idx_q;
      key_d     = key_q;
      pressed_d = pressed_q;
      unique case (state_q)
         SCAN: begin
            if (cnt_q == SettleLast) begin
               cnt_d = 8'd0;
               if (row_sync != 4'hF) begin
                  row_idx_d = low_row;
                  key_d     = decode_key(low_row, col_idx_q);
                  pressed_d = 1'b1;
                  state_d   = HOLD;
               end else begin
                  col_idx_d = col_idx_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         HOLD: begin
            if (row_sync[row_idx_q]) begin
               if (cnt_q == ReleaseLast) begin
                  cnt_d     = 8'd0;
                  pressed_d = 1'b0;
                  col_idx_d = col_idx_q + 2'd1;
                  state_d   = SCAN;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end else begin
               cnt_d = 8'd0;
            end
         end
         default: state_d = SCAN;
      endcase
      cols_d = ~(4'b0001 << col_idx_d);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= SCAN;
         cnt_q     <= 8'd0;
         col_idx_q <= 2'd0;
         row_idx_q <= 2'd0;
         key_q     <= 4'h0;
         pressed_q <= 1'b0;
         cols_q    <= 4'b1110;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         col_idx_q <= col_idx_d;
         row_idx_q <= row_idx_d;
         key_q     <= key_d;
         pressed_q <= pressed_d;
         cols_q    <= cols_d;
      end
   end

   assign cols       = cols_q;
   assign keyDecoded = key_q;
   assign keyPressed = pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: keypad matrix model drives rows from cols; reference model checks every cycle.
module tb_keypad_scanner;

   localparam int S = 4;
   localparam int R = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] rows = 4'hF;
   logic [3:0] cols;
   logic [3:0] keyDecoded;
   logic       keyPressed;

   int n_vec = 0;
   int n_err = 0;

   keypad_scanner #(
      .SETTLE_CYCLES  (S),
      .RELEASE_CYCLES (R)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rows       (rows),
      .cols       (cols),
      .keyDecoded (keyDecoded),
      .keyPressed (keyPressed)
   );

   always #5 clk = ~clk;

   // Key code by row*4+col.
   int key_map [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

   // Reference model: time since scan (re)start determines the column;
   // holding tracks the run length of consecutive high samples on the held row.
   bit         m_hold;
   int         m_elapsed, m_base, m_hcol, m_hrow, m_run;
   logic [3:0] m_key;
   bit         m_pressed;
   logic [3:0] m_h1, m_h2;

   function automatic int m_col();
      return m_hold ? m_hcol : (m_base + m_elapsed / S) % 4;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input logic rst_n, input logic [3:0] r);
      logic [3:0] rs;
      if (!rst_n) begin
         m_hold = 0; m_elapsed = 0; m_base = 0; m_hcol = 0; m_hrow = 0; m_run = 0;
         m_key = 4'h0; m_pressed = 0; m_h1 = 4'hF; m_h2 = 4'hF;
      end else begin
         rs   = m_h2;
         m_h2 = m_h1;
         m_h1 = r;
         if (!m_hold) begin
            if ((m_elapsed % S) == S - 1 && rs != 4'hF) begin
               m_hcol = m_col();
               for (int i = 3; i >= 0; i--) if (!rs[i]) m_hrow = i;
               m_key     = 4'(key_map[m_hrow * 4 + m_hcol]);
               m_pressed = 1;
               m_hold    = 1;
               m_run     = 0;
            end else begin
               m_elapsed++;
            end
         end else if (rs[m_hrow]) begin
            m_run++;
            if (m_run == R) begin
               m_pressed = 0;
               m_hold    = 0;
               m_base    = m_hcol + 1;
               m_elapsed = 0;
            end
         end else begin
            m_run = 0;
         end
      end
   endtask

   // One clock: keypad drives rows from live cols, model advances, outputs checked at negedge.
   task automatic tick(input logic rst_n, input logic [15:0] keys, input logic [3:0] glitch);
      logic [3:0] r;
      logic [3:0] exp_cols;
      r = 4'hF;
      if (rst_n) begin
         for (int ri = 0; ri < 4; ri++)
            for (int ci = 0; ci < 4; ci++)
               if (keys[ri * 4 + ci] && cols[ci] === 1'b0) r[ri] = 1'b0;
         r = r | glitch;
      end
      rows  = r;
      reset = rst_n;
      model_step(rst_n, r);
      @(negedge clk);
      exp_cols = ~(4'b0001 << m_col());
      check_eq("cols", 32'(cols), 32'(exp_cols));
      check_eq("keyPressed", 32'(keyPressed), 32'(m_pressed));
      check_eq("keyDecoded", 32'(keyDecoded), 32'(m_key));
   endtask

   localparam logic [15:0] K5 = 16'h0020;
   localparam logic [15:0] K8 = 16'h0200;
   localparam logic [15:0] K0 = 16'h2000;
   localparam logic [15:0] KA = 16'h0008;
   localparam logic [15:0] KD = 16'h8000;

   initial begin
      logic [15:0] keys;
      logic [3:0]  glitch;
      logic        rst_n;
      int          dur;
      int          nk;

      // Reset and idle scanning.
      repeat (2) tick(1'b0, 16'h0, 4'h0);
      check_eq("reset_cols", 32'(cols), 32'h0000_000E);
      check_eq("reset_pressed", 32'(keyPressed), 32'h0);
      check_eq("reset_key", 32'(keyDecoded), 32'h0);
      repeat (40) tick(1'b1, 16'h0, 4'h0);

      // Key "5", then a short release glitch, then a real release.
      repeat (30) tick(1'b1, K5, 4'h0);
      check_eq("k5_key", 32'(keyDecoded), 32'h5);
      check_eq("k5_cols", 32'(cols), 32'h0000_000D);
      repeat (2) tick(1'b1, K5, 4'b0010);
      repeat (10) tick(1'b1, K5, 4'h0);
      check_eq("glitch_pressed", 32'(keyPressed), 32'h1);
      check_eq("glitch_cols", 32'(cols), 32'h0000_000D);
      repeat (4) tick(1'b1, 16'h0, 4'h0);
      check_eq("rel_early_pressed", 32'(keyPressed), 32'h1);
      tick(1'b1, 16'h0, 4'h0);
      check_eq("rel_pressed", 32'(keyPressed), 32'h0);
      check_eq("rel_cols", 32'(cols), 32'h0000_000B);
      check_eq("rel_key", 32'(keyDecoded), 32'h5);
      repeat (10) tick(1'b1, 16'h0, 4'h0);

      // Two keys in one column, then a key in another column during hold.
      repeat (30) tick(1'b1, K8 | K0, 4'h0);
      check_eq("k8_key", 32'(keyDecoded), 32'h8);
      repeat (20) tick(1'b1, K8 | K0 | KA, 4'h0);
      check_eq("kA_ignored", 32'(keyDecoded), 32'h8);
      check_eq("kA_cols", 32'(cols), 32'h0000_000D);
      repeat (10) tick(1'b1, 16'h0, 4'h0);

      // Reset in the middle of a hold.
      repeat (30) tick(1'b1, KD, 4'h0);
      check_eq("kD_pressed", 32'(keyPressed), 32'h1);
      check_eq("kD_key", 32'(keyDecoded), 32'hD);
      tick(1'b0, KD, 4'h0);
      check_eq("rst_hold_pressed", 32'(keyPressed), 32'h0);
      check_eq("rst_hold_key", 32'(keyDecoded), 32'h0);
      check_eq("rst_hold_cols", 32'(cols), 32'h0000_000E);

      // Randomized key sets, glitches and occasional resets.
      for (int ph = 0; ph < 150; ph++) begin
         keys = 16'h0;
         nk   = $urandom_range(0, 2);
         for (int k = 0; k < nk; k++) keys[$urandom_range(0, 15)] = 1'b1;
         dur = $urandom_range(1, 60);
         for (int c = 0; c < dur; c++) begin
            glitch = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
            rst_n  = ($urandom_range(0, 299) != 0);
            tick(rst_n, keys, glitch);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Drives the columns of a 4x4 matrix keypad and samples its rows. Produces the `keyDecoded`/`keyPressed` pair consumed by the downstream keypad debouncer/shifter path. It is the producer end of that interface. While a key is held, the scanner locks onto that key's column and keeps both outputs stable. It resumes scanning only after a confirmed release, so downstream logic sees one continuous press per keystroke.

## Interface
- `SETTLE_CYCLES`, default 8: cycles a column is driven before its rows are sampled. Legal range 2..255.
- `RELEASE_CYCLES`, default 16: consecutive cycles the held row must read high before release is accepted. Legal range 1..255.
- `clk` input, 1 bit: system clock. All state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-low reset.
- `rows` input, 4 bits: keypad rows. Active-low, with external pull-ups. Asynchronous to `clk`.
- `cols` output, 4 bits: column drive. One-hot active-low (exactly one bit is 0 at all times).
- `keyDecoded` output, 4 bits: hex code of the held key.
- `keyPressed` output, 1 bit: high while a key is held.

## Operation
- `rows` passes through a 2-flop synchronizer to form `rowSync`. All decisions use `rowSync`.
- State machine has two states: SCAN and HOLD.
- SCAN:
  - `cols` drives column `colIdx` low; a counter increments every cycle.
  - When the counter reaches `SETTLE_CYCLES-1`, sample `rowSync`.
  - If any bit is 0: latch `rowIdx` as the lowest-index low row, latch `colIdx`, load `keyDecoded`, set `keyPressed`=1, clear the counter, go to HOLD.
  - Otherwise: `colIdx` advances (3 wraps to 0), clear the counter, stay in SCAN.
- HOLD:
  - `cols` stays on the latched column. Other columns and rows are ignored.
  - While `rowSync[rowIdx]`=1, the counter increments; any 0 clears it.
  - When the counter reaches `RELEASE_CYCLES-1` with the row still high: `keyPressed`=0, `colIdx` advances, clear the counter, go to SCAN.
  - `keyDecoded` holds its last value after release.
- Decode map (row,col), with row0 at the top:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D (E = "*", F = "#")
- Boundary rules:
  - Multiple rows low in the sampled column: the lowest row index wins.
  - A second key pressed while in HOLD is ignored. If it is still held after release, it is picked up on the next scan that reaches its column.
  - A glitch on the held row shorter than `RELEASE_CYCLES` does not drop `keyPressed`.
  - Reset asserted mid-HOLD or mid-SCAN: all state returns to reset values on that edge.

## Timing
- Reset values:
  - `cols`=4'b1110 (column 0)
  - `keyPressed`=0
  - `keyDecoded`=4'h0
  - state SCAN, counter 0, `colIdx`=0, synchronizer flops all 1
- All outputs are registered; there is no combinational path from `rows` to any output.
- Column dwell in SCAN with no key pressed is exactly `SETTLE_CYCLES` cycles. A full scan of four columns takes `4*SETTLE_CYCLES` cycles.
- `keyPressed` and `keyDecoded` update on the same edge, one edge after the sampling cycle.
- Press latency: a row goes low while its column is driven. `keyPressed` rises at most `SETTLE_CYCLES+2` cycles later, provided the press occurs early enough in the dwell to clear the 2-cycle synchronizer.
- Release latency: `keyPressed` falls `2+RELEASE_CYCLES` cycles after `rows` goes high. `cols` moves to the next column on that same edge.

## Structure
- Package `keypad_pkg` holds:
  - state enum `scan_state_t` {SCAN, HOLD}
  - the 16-entry decode constant table, indexed {row,col}
  - a function `decode_key(row,col)`
- Sub-module `sync2`: 4-bit 2-flop synchronizer, reset to all 1s.
- Counter is 8 bits, shared between SCAN and HOLD.

## Test plan
All scenarios use `SETTLE_CYCLES`=4 and `RELEASE_CYCLES`=3.
- Reset and idle: `reset`=0 for 2 cycles, then `rows`=4'hF for 40 cycles.
  - `cols` sequence is 1110, 1101, 1011, 0111, repeating, 4 cycles per step.
  - `keyPressed` stays 0 and `keyDecoded` stays 4'h0.
- Single key "5" (row1, col1): hold `rows[1]`=0 whenever `cols`=1101.
  - `keyDecoded`=4'h5 and `keyPressed`=1 within 6 cycles of column 1 activating.
  - `cols` frozen at 1101 while the key is held.
- Release: after the "5" press, set `rows`=4'hF.
  - `keyPressed` falls exactly 5 cycles later.
  - `cols` advances to 1011 on the same edge.
  - `keyDecoded` stays 4'h5.
- Release glitch: while "5" is held, pulse `rows[1]` high for 2 cycles.
  - `keyPressed` stays 1 and `cols` does not move.
- Two keys, same column: press "8" (row2, col1) and "0" (row3, col1) together.
  - `keyDecoded`=4'h8.
  - Pressing "A" (row0, col3) during that HOLD has no effect.
- Reset mid-HOLD: with "D" (row3, col3) held and `keyPressed`=1, drive `reset`=0 for 1 cycle.
  - Next edge: `keyPressed`=0, `keyDecoded`=4'h0, `cols`=1110.
